// File: rtl/alu_cmd_sequencer.sv
// Command FIFO that replays {Function,Data} pairs onto an ALU register, driving
// Function=111 (hold) between commands and whenever no playback is in progress.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Push,
    input  logic [6:0]               PushCmd,
    input  logic                     Run,
    output logic [3:0]               Data,
    output logic [2:0]               Function,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [2:0]  FnHold = 3'b111;

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StFin} state_e;

    state_e              state_q;
    logic [3:0]          gap_cnt_q;
    logic [3:0]          data_q;
    logic [2:0]          func_q;
    logic                done_q;
    logic                overflow_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic [PtrW:0]       count_d;
    logic [6:0]          mem [DEPTH];
    logic [6:0]          head;
    logic                push_acc;
    logic                pop;

    assign Full     = (count_q == (PtrW + 1)'(DEPTH));
    assign Empty    = (count_q == '0);
    assign Count    = count_q;
    assign Data     = data_q;
    assign Function = func_q;
    assign Done     = done_q;
    assign Overflow = overflow_q;
    assign Busy     = (state_q == StIssue) || (state_q == StGap);

    assign head     = mem[rd_ptr_q];
    // Full is judged on the pre-edge count even if a pop happens in the same cycle.
    assign push_acc = Push && !Full;
    assign pop      = (state_q == StIssue) && !Empty;

    always_comb begin
        count_d = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= PushCmd;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            if (Push && Full) overflow_q <= 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            data_q    <= '0;
            func_q    <= FnHold;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    func_q <= FnHold;
                    data_q <= '0;
                    if (Run) state_q <= Empty ? StFin : StIssue;
                end
                StIssue: begin
                    {func_q, data_q} <= head;
                    // Remaining entries include any command accepted this same cycle.
                    if (GAP != 0) begin
                        state_q   <= StGap;
                        gap_cnt_q <= 4'(GAP);
                    end else if (count_d != '0) begin
                        state_q <= StIssue;
                    end else begin
                        state_q <= StFin;
                    end
                end
                StGap: begin
                    func_q    <= FnHold;
                    data_q    <= '0;
                    gap_cnt_q <= gap_cnt_q - 1'b1;
                    if (gap_cnt_q == 4'd1) state_q <= (count_d != '0) ? StIssue : StFin;
                end
                StFin: begin
                    func_q  <= FnHold;
                    data_q  <= '0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one GAP=0 and one GAP=2 instance share stimulus.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       push;
    logic [6:0] push_cmd;
    logic       run;

    logic [3:0] data0, data2;
    logic [2:0] func0, func2;
    logic       full0, full2, empty0, empty2, busy0, busy2, done0, done2, ovf0, ovf2;
    logic [2:0] count0, count2;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_sequencer #(.DEPTH(4), .GAP(0)) dut0 (
        .Clock(clk), .Reset(rst), .Push(push), .PushCmd(push_cmd), .Run(run),
        .Data(data0), .Function(func0), .Full(full0), .Empty(empty0), .Count(count0),
        .Busy(busy0), .Done(done0), .Overflow(ovf0)
    );

    alu_cmd_sequencer #(.DEPTH(4), .GAP(2)) dut2 (
        .Clock(clk), .Reset(rst), .Push(push), .PushCmd(push_cmd), .Run(run),
        .Data(data2), .Function(func2), .Full(full2), .Empty(empty2), .Count(count2),
        .Busy(busy2), .Done(done2), .Overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sel 0 -> GAP=0 instance, otherwise GAP=2 instance
    task automatic chk_out(input string tag, input int sel, input logic [2:0] f,
                           input logic [3:0] d, input logic dn, input logic bz);
        check({tag, " func"}, (sel == 0) ? func0 : func2, f);
        check({tag, " data"}, (sel == 0) ? data0 : data2, d);
        check({tag, " done"}, (sel == 0) ? done0 : done2, dn);
        check({tag, " busy"}, (sel == 0) ? busy0 : busy2, bz);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [6:0] cmd);
        push = 1'b1;
        push_cmd = cmd;
        tick();
        push = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; push_cmd = '0; run = 1'b0;

        // Reset state
        do_reset();
        chk_out("rst", 0, 3'b111, 4'd0, 1'b0, 1'b0);
        check("rst empty", empty0, 1'b1);
        check("rst full", full0, 1'b0);
        check("rst count", count0, 3'd0);
        check("rst ovf", ovf0, 1'b0);

        // Two commands back-to-back with GAP=0
        push_one(7'b000_0011);
        push_one(7'b000_0101);
        check("t1 count", count0, 3'd2);
        start_run();
        chk_out("t1 k", 0, 3'b111, 4'd0, 1'b0, 1'b1);
        tick();
        chk_out("t1 c1", 0, 3'b000, 4'd3, 1'b0, 1'b1);
        tick();
        chk_out("t1 c2", 0, 3'b000, 4'd5, 1'b0, 1'b0);
        check("t1 empty", empty0, 1'b1);
        tick();
        chk_out("t1 fin", 0, 3'b111, 4'd0, 1'b1, 1'b0);
        tick();
        chk_out("t1 idle", 0, 3'b111, 4'd0, 1'b0, 1'b0);

        // Overflow: fifth push into a full DEPTH=4 FIFO is dropped
        do_reset();
        push_one(7'h01);
        push_one(7'h02);
        push_one(7'h03);
        check("t2 not full", full0, 1'b0);
        push_one(7'h04);
        check("t2 full", full0, 1'b1);
        check("t2 count4", count0, 3'd4);
        check("t2 no ovf yet", ovf0, 1'b0);
        push_one(7'h05);
        check("t2 ovf", ovf0, 1'b1);
        check("t2 count kept", count0, 3'd4);
        tick();
        check("t2 ovf sticky", ovf0, 1'b1);

        // GAP=2 pattern
        do_reset();
        check("t3 ovf cleared", ovf2, 1'b0);
        push_one(7'b001_0001);
        push_one(7'b010_0010);
        start_run();
        chk_out("t3 k", 2, 3'b111, 4'd0, 1'b0, 1'b1);
        tick();
        chk_out("t3 c1", 2, 3'b001, 4'd1, 1'b0, 1'b1);
        tick();
        chk_out("t3 g1a", 2, 3'b111, 4'd0, 1'b0, 1'b1);
        tick();
        chk_out("t3 g1b", 2, 3'b111, 4'd0, 1'b0, 1'b1);
        tick();
        chk_out("t3 c2", 2, 3'b010, 4'd2, 1'b0, 1'b1);
        tick();
        chk_out("t3 g2a", 2, 3'b111, 4'd0, 1'b0, 1'b1);
        tick();
        chk_out("t3 g2b", 2, 3'b111, 4'd0, 1'b0, 1'b0);
        tick();
        chk_out("t3 fin", 2, 3'b111, 4'd0, 1'b1, 1'b0);
        tick();
        chk_out("t3 idle", 2, 3'b111, 4'd0, 1'b0, 1'b0);

        // Run with an empty FIFO
        do_reset();
        start_run();
        chk_out("t4 k", 0, 3'b111, 4'd0, 1'b0, 1'b0);
        tick();
        chk_out("t4 done", 0, 3'b111, 4'd0, 1'b1, 1'b0);
        tick();
        chk_out("t4 idle", 0, 3'b111, 4'd0, 1'b0, 1'b0);

        // Push during issue, with pointers wrapping past DEPTH
        do_reset();
        push_one(7'b000_0001);
        push_one(7'b000_0010);
        push_one(7'b000_0011);
        start_run();
        tick();
        chk_out("t5 pre1", 0, 3'b000, 4'd1, 1'b0, 1'b1);
        tick();
        chk_out("t5 pre2", 0, 3'b000, 4'd2, 1'b0, 1'b1);
        tick();
        chk_out("t5 pre3", 0, 3'b000, 4'd3, 1'b0, 1'b0);
        tick();
        tick();
        push_one(7'b001_0100);
        push_one(7'b010_0101);
        start_run();
        push_one(7'b110_0010);
        chk_out("t5 c1", 0, 3'b001, 4'd4, 1'b0, 1'b1);
        check("t5 count", count0, 3'd2);
        tick();
        chk_out("t5 c2", 0, 3'b010, 4'd5, 1'b0, 1'b1);
        tick();
        chk_out("t5 c3", 0, 3'b110, 4'd2, 1'b0, 1'b0);
        tick();
        chk_out("t5 fin", 0, 3'b111, 4'd0, 1'b1, 1'b0);
        check("t5 empty", empty0, 1'b1);

        // Reset in the middle of playback
        do_reset();
        push_one(7'b000_0001);
        push_one(7'b000_0010);
        push_one(7'b000_0011);
        push_one(7'b000_0100);
        start_run();
        tick();
        chk_out("t6 c1", 0, 3'b000, 4'd1, 1'b0, 1'b1);
        tick();
        chk_out("t6 c2", 0, 3'b000, 4'd2, 1'b0, 1'b1);
        do_reset();
        chk_out("t6 rst", 0, 3'b111, 4'd0, 1'b0, 1'b0);
        check("t6 count", count0, 3'd0);
        check("t6 empty", empty0, 1'b1);
        tick();
        chk_out("t6 idle", 0, 3'b111, 4'd0, 1'b0, 1'b0);
        tick();
        check("t6 no done", done0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
